set_assoc_cache: RTL and testbench
==================================

SET_ASSOC_CACHE -- requirements
Module: set_assoc_cache

Interface
REQ-001 Parameter ADDR_W, default 16, word-address width.
REQ-002 Parameter DATA_W, default 32, data word width.
REQ-003 Parameter INDEX_W, default 4, set index bits (2**INDEX_W sets).
REQ-004 Parameter WAYS, default 2, associativity; legal values 1 or 2.
REQ-005 Clocking SHALL be: reset reset, synchronous, active-high; clock clk.
REQ-006 clk  in  1  clock.
REQ-007 reset  in  1  synchronous active-high reset.
REQ-008 cpu_req  in  1  CPU access request, held until cpu_ready.
REQ-009 cpu_we  in  1  1=write, 0=read.
REQ-010 cpu_addr  in  ADDR_W  word address; index=[INDEX_W-1:0], tag=[ADDR_W-1:INDEX_W].
REQ-011 cpu_wdata  in  DATA_W  write data.
REQ-012 cpu_rdata  out  DATA_W  read data, valid when cpu_ready and a read is active.
REQ-013 cpu_ready  out  1  access completes this cycle.
REQ-014 hit  out  1  combinational tag match on a valid way for cpu_addr.
REQ-015 mem_req/mem_we  out  1/1  backing-memory request/write, held until mem_ack.
REQ-016 mem_addr  out  ADDR_W; mem_wdata  out  DATA_W; mem_rdata  in  DATA_W.
REQ-017 mem_ack  in  1  one-cycle completion pulse from memory.

Function
REQ-018 FSM states SHALL be IDLE, MISS, FILL, WRITE.
REQ-019 IDLE, cpu_req=1, cpu_we=0, hit=1: cpu_ready=1 same cycle, cpu_rdata=hit way data; LRU updated at edge; stay IDLE.
REQ-020 IDLE, read miss: cpu_ready=0; next state MISS.
REQ-021 MISS: mem_req=1, mem_we=0, mem_addr=cpu_addr; on mem_ack, victim way written {valid=1, tag, mem_rdata}; next state FILL.
REQ-022 Victim: first invalid way (way 0 before way 1), else LRU way; WAYS=1 always way 0.
REQ-023 FILL: cpu_ready=1, cpu_rdata=filled data, LRU marks filled way MRU; next state IDLE.
REQ-024 Read-miss latency SHALL be memory latency plus 2 cycles from request to cpu_ready.
REQ-025 IDLE write: next state WRITE (write-through, no-write-allocate).
REQ-026 WRITE: mem_req=1, mem_we=1, mem_addr=cpu_addr, mem_wdata=cpu_wdata; cpu_ready=mem_ack combinationally; on ack, a hitting way is updated and made MRU, a miss leaves the array unchanged; next state IDLE.
REQ-027 mem_ack outside MISS/WRITE SHALL be ignored; mem_req never drops before ack.
REQ-028 cpu_req=0 in IDLE: no state, array or LRU change; cpu_ready=0.
REQ-029 Back-to-back requests SHALL be accepted in the cycle after cpu_ready.

Reset
REQ-030 Reset SHALL clear all valid bits and LRU bits, state to IDLE; cpu_ready, mem_req, mem_we = 0 from the cycle after reset.
REQ-031 Reset mid-MISS/WRITE SHALL abort without array update; a subsequent late mem_ack is ignored.
REQ-032 Data/tag contents need not be reset.

Configuration
REQ-033 With CACHE_STATS_EN defined: outputs hit_count, miss_count (32 bits) count completed read hits / read misses, saturate at all-ones, clear on reset.
REQ-034 Without CACHE_STATS_EN: these ports and counters SHALL not exist; other behaviour identical.

Structure
REQ-035 Package cache_pkg SHALL hold the FSM state enum and a TAG_W derivation function (ADDR_W-INDEX_W).
REQ-036 Sub-module cache_way (one instance per way) SHALL hold the valid/tag/data arrays and the tag compare.

Verification
REQ-037 Reset, read 0x0013 with 3-cycle memory returning 0xDEADBEEF -> cpu_ready 5 cycles after request, data 0xDEADBEEF; re-read -> hit, same-cycle ready.
REQ-038 WAYS=2: reads 0x0003, 0x0013, 0x0003, 0x0023 -> last evicts 0x0013 (LRU); read 0x0003 hits, 0x0013 misses.
REQ-039 Write 0x0005=0x12345678 on miss -> mem write issued, next read of 0x0005 misses; after fill, write 0x0005=0x0BADF00D -> subsequent read hits returning 0x0BADF00D.
REQ-040 Reset asserted during MISS, mem_ack one cycle later -> no fill, mem_req=0, next read of same address misses.
REQ-041 WAYS=1: alternate reads 0x0007/0x0017 -> every access misses.
REQ-042 CACHE_STATS_EN: REQ-037 sequence -> hit_count=1, miss_count=1.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared types for the set-associative cache: controller state encoding and
// tag-width derivation.
package cache_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MISS  = 2'd1,
    FILL  = 2'd2,
    WRITE = 2'd3
  } state_t;

  function automatic int unsigned calc_tag_w(input int unsigned addr_w,
                                             input int unsigned index_w);
    return addr_w - index_w;
  endfunction

endpackage

// File: rtl/cache_way.sv
// One cache way: valid/tag/data arrays with a single write port and a
// combinational tag compare at the looked-up index.
module cache_way #(
  parameter int unsigned INDEX_W = 4,
  parameter int unsigned TAG_W   = 12,
  parameter int unsigned DATA_W  = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [INDEX_W-1:0] index,
  input  logic [TAG_W-1:0]   tag,
  input  logic               wr_en,
  input  logic [DATA_W-1:0]  wr_data,
  output logic               valid_c,
  output logic               match_c,
  output logic [DATA_W-1:0]  rdata_c
);

  localparam int unsigned SETS = 2 ** INDEX_W;

  logic [SETS-1:0]   valid_q;
  logic [TAG_W-1:0]  tag_q  [SETS];
  logic [DATA_W-1:0] data_q [SETS];

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
    end else if (wr_en) begin
      valid_q[index] <= 1'b1;
    end
  end

  // Tag and data contents are deliberately left unreset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_q[index]  <= tag;
      data_q[index] <= wr_data;
    end
  end

  assign valid_c = valid_q[index];
  assign match_c = valid_q[index] && (tag_q[index] == tag);
  assign rdata_c = data_q[index];

endmodule

// File: rtl/set_assoc_cache.sv
// Write-through, no-write-allocate, 1- or 2-way set-associative cache with LRU.
// Define CACHE_STATS_EN to add saturating read hit/miss counters.
module set_assoc_cache
  import cache_pkg::*;
#(
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned INDEX_W = 4,
  parameter int unsigned WAYS    = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ready,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              hit
`ifdef CACHE_STATS_EN
  ,
  output logic [31:0]       hit_count,
  output logic [31:0]       miss_count
`endif
);

  localparam int unsigned TAG_W = calc_tag_w(ADDR_W, INDEX_W);
  localparam int unsigned SETS  = 2 ** INDEX_W;

  state_t state, state_nxt;

  logic [INDEX_W-1:0] index;
  logic [TAG_W-1:0]   tag;
  logic [WAYS-1:0]    way_valid, way_match, way_we;
  logic [DATA_W-1:0]  way_rdata [WAYS];
  logic [DATA_W-1:0]  way_wdata, hit_data;
  logic               hit_way, victim_way;
  logic [SETS-1:0]    lru_q;
  logic               fill_en, wr_hit_en, lru_upd;

  assign index     = cpu_addr[INDEX_W-1:0];
  assign tag       = cpu_addr[ADDR_W-1:INDEX_W];
  assign way_wdata = (state == MISS) ? mem_rdata : cpu_wdata;

  for (genvar w = 0; w < WAYS; w++) begin : g_way
    assign way_we[w] = !reset && ((fill_en && (victim_way == 1'(w))) ||
                                  (wr_hit_en && way_match[w]));
    cache_way #(
      .INDEX_W (INDEX_W),
      .TAG_W   (TAG_W),
      .DATA_W  (DATA_W)
    ) u_way (
      .clk     (clk),
      .reset   (reset),
      .index   (index),
      .tag     (tag),
      .wr_en   (way_we[w]),
      .wr_data (way_wdata),
      .valid_c (way_valid[w]),
      .match_c (way_match[w]),
      .rdata_c (way_rdata[w])
    );
  end

  // lru_q[set] holds the least-recently-used way of that set.
  if (WAYS == 2) begin : g_sel2
    assign hit_way    = way_match[1];
    assign hit_data   = way_match[1] ? way_rdata[1] : way_rdata[0];
    assign victim_way = !way_valid[0] ? 1'b0 :
                        !way_valid[1] ? 1'b1 : lru_q[index];
  end else begin : g_sel1
    assign hit_way    = 1'b0;
    assign hit_data   = way_rdata[0];
    assign victim_way = 1'b0;
  end

  assign hit       = |way_match;
  assign cpu_rdata = hit_data;
  assign mem_addr  = cpu_addr;
  assign mem_wdata = cpu_wdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      lru_q <= '0;
    end else if (lru_upd) begin
      lru_q[index] <= ~hit_way;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cpu_req) state_nxt = cpu_we ? WRITE : (hit ? IDLE : MISS);
      MISS:    if (mem_ack) state_nxt = FILL;
      FILL:    state_nxt = IDLE;
      WRITE:   if (mem_ack) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // In FILL the freshly written way matches, so hit_data/hit_way cover it.
  always_comb begin
    cpu_ready = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    fill_en   = 1'b0;
    wr_hit_en = 1'b0;
    lru_upd   = 1'b0;
    case (state)
      IDLE: begin
        cpu_ready = cpu_req && !cpu_we && hit;
        lru_upd   = cpu_req && !cpu_we && hit;
      end
      MISS: begin
        mem_req = 1'b1;
        fill_en = mem_ack;
      end
      FILL: begin
        cpu_ready = 1'b1;
        lru_upd   = 1'b1;
      end
      WRITE: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        cpu_ready = mem_ack;
        wr_hit_en = mem_ack && hit;
        lru_upd   = mem_ack && hit;
      end
      default: ;
    endcase
  end

`ifdef CACHE_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (state == IDLE && cpu_ready && hit_count != '1) hit_count <= hit_count + 32'd1;
      if (state == FILL && miss_count != '1) miss_count <= miss_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_set_assoc_cache.sv
// Scoreboard bench for set_assoc_cache: a 2-way and a 1-way instance share one
// CPU driver and a fixed-latency memory model.
module tb_set_assoc_cache;

  localparam int LAT = 3;

  logic clk = 1'b0;
  logic reset, cpu_req, cpu_we, sel, late_ack;
  logic [15:0] cpu_addr;
  logic [31:0] cpu_wdata;

  logic        req_v [2];
  logic        ready_v [2];
  logic        hit_v [2];
  logic [31:0] rdata_v [2];
  logic        mem_req_v [2];
  logic        mem_we_v [2];
  logic        mem_ack_v [2];
  logic [15:0] mem_addr_v [2];
  logic [31:0] mem_wdata_v [2];
  logic [31:0] mem_rdata_v [2];
`ifdef CACHE_STATS_EN
  logic [31:0] hc_v [2];
  logic [31:0] mc_v [2];
`endif

  logic [31:0] mem_model [65536];

  logic        cur_rdy, cur_hit;
  logic [31:0] cur_rdata;

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [31:0] data;
    logic        exp_hit;
    int          lat;
    int          issue;
  } item_t;

  item_t sb[$];
  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign req_v[0]       = cpu_req && !sel;
  assign req_v[1]       = cpu_req && sel;
  assign mem_rdata_v[0] = mem_model[mem_addr_v[0]];
  assign mem_rdata_v[1] = mem_model[mem_addr_v[1]];
  assign cur_rdy        = sel ? ready_v[1] : ready_v[0];
  assign cur_hit        = sel ? hit_v[1]   : hit_v[0];
  assign cur_rdata      = sel ? rdata_v[1] : rdata_v[0];

  set_assoc_cache #(.ADDR_W(16), .DATA_W(32), .INDEX_W(4), .WAYS(2)) u_dut2 (
    .clk(clk), .reset(reset), .cpu_req(req_v[0]), .cpu_we(cpu_we),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(rdata_v[0]),
    .cpu_ready(ready_v[0]), .mem_req(mem_req_v[0]), .mem_we(mem_we_v[0]),
    .mem_addr(mem_addr_v[0]), .mem_wdata(mem_wdata_v[0]),
    .mem_rdata(mem_rdata_v[0]), .mem_ack(mem_ack_v[0]), .hit(hit_v[0])
`ifdef CACHE_STATS_EN
    , .hit_count(hc_v[0]), .miss_count(mc_v[0])
`endif
  );

  set_assoc_cache #(.ADDR_W(16), .DATA_W(32), .INDEX_W(4), .WAYS(1)) u_dut1 (
    .clk(clk), .reset(reset), .cpu_req(req_v[1]), .cpu_we(cpu_we),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(rdata_v[1]),
    .cpu_ready(ready_v[1]), .mem_req(mem_req_v[1]), .mem_we(mem_we_v[1]),
    .mem_addr(mem_addr_v[1]), .mem_wdata(mem_wdata_v[1]),
    .mem_rdata(mem_rdata_v[1]), .mem_ack(mem_ack_v[1]), .hit(hit_v[1])
`ifdef CACHE_STATS_EN
    , .hit_count(hc_v[1]), .miss_count(mc_v[1])
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Memory: acks LAT cycles after mem_req first appears; late_ack injects a stray pulse.
  initial begin : mem_responder
    int cnt [2];
    cnt[0] = 0;
    cnt[1] = 0;
    mem_ack_v[0] = 1'b0;
    mem_ack_v[1] = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      for (int k = 0; k < 2; k++) begin
        mem_ack_v[k] = 1'b0;
        if (mem_req_v[k]) begin
          if (cnt[k] == LAT) begin
            mem_ack_v[k] = 1'b1;
            cnt[k] = 0;
            if (mem_we_v[k]) mem_model[mem_addr_v[k]] = mem_wdata_v[k];
          end else begin
            cnt[k]++;
          end
        end else begin
          cnt[k] = 0;
        end
      end
      if (late_ack) begin
        mem_ack_v[0] = 1'b1;
        late_ack = 1'b0;
      end
    end
  end

  initial begin : monitor
    item_t it;
    forever begin
      @(negedge clk);
      if (cpu_req && !reset && cur_rdy) begin
        check("sb_pending", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          it = sb.pop_front();
          check($sformatf("latency_%04h", it.addr), 32'(cyc - it.issue), 32'(it.lat));
          check($sformatf("hit_%04h", it.addr), 32'(cur_hit), 32'(it.exp_hit));
          if (!it.we) check($sformatf("rdata_%04h", it.addr), cur_rdata, it.data);
        end
      end
    end
  end

  task automatic access(input logic we, input logic [15:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_data, input logic exp_hit, input int lat);
    item_t it;
    int n;
    it.we = we; it.addr = addr; it.data = exp_data;
    it.exp_hit = exp_hit; it.lat = lat; it.issue = cyc;
    sb.push_back(it);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!cur_rdy && n < 100);
    if (!cur_rdy) begin
      check("ready_timeout", 32'(cur_rdy), 32'd1);
      sb.delete();
    end
    @(posedge clk);
    #1;
    cpu_req = 1'b0;
  endtask

  task automatic do_reset();
    cpu_req = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic check_idle(input string tag_s);
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      check($sformatf("%s_ready%0d", tag_s, k), 32'(ready_v[k]), 32'd0);
      check($sformatf("%s_mem_req%0d", tag_s, k), 32'(mem_req_v[k]), 32'd0);
      check($sformatf("%s_mem_we%0d", tag_s, k), 32'(mem_we_v[k]), 32'd0);
      check($sformatf("%s_hit%0d", tag_s, k), 32'(hit_v[k]), 32'd0);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : main
    reset = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 16'h0013;
    cpu_wdata = '0; sel = 1'b0; late_ack = 1'b0;
    for (int i = 0; i < 65536; i++) mem_model[i] = 32'hC0DE_0000 | 32'(i);
    mem_model[16'h0013] = 32'hDEAD_BEEF;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check_idle("reset");

    // 3-cycle memory: miss ready 5 cycles after request, then a same-cycle hit
    access(1'b0, 16'h0013, '0, 32'hDEAD_BEEF, 1'b1, 5);
    access(1'b0, 16'h0013, '0, 32'hDEAD_BEEF, 1'b1, 0);
`ifdef CACHE_STATS_EN
    check("hit_count", hc_v[0], 32'd1);
    check("miss_count", mc_v[0], 32'd1);
`endif

    // Reset must invalidate 0x0013 (cpu_addr still points at it)
    cpu_addr = 16'h0013;
    do_reset();
    check_idle("reset2");
`ifdef CACHE_STATS_EN
    check("hit_count_clr", hc_v[0], 32'd0);
    check("miss_count_clr", mc_v[0], 32'd0);
`endif

    // LRU eviction in set 3
    access(1'b0, 16'h0003, '0, 32'hC0DE_0003, 1'b1, 5);
    access(1'b0, 16'h0013, '0, 32'hDEAD_BEEF, 1'b1, 5);
    access(1'b0, 16'h0003, '0, 32'hC0DE_0003, 1'b1, 0);
    access(1'b0, 16'h0023, '0, 32'hC0DE_0023, 1'b1, 5);
    access(1'b0, 16'h0003, '0, 32'hC0DE_0003, 1'b1, 0);
    access(1'b0, 16'h0013, '0, 32'hDEAD_BEEF, 1'b1, 5);

    // Write-through, no-write-allocate, then write-hit update
    do_reset();
    access(1'b1, 16'h0005, 32'h1234_5678, '0, 1'b0, 4);
    access(1'b0, 16'h0005, '0, 32'h1234_5678, 1'b1, 5);
    access(1'b1, 16'h0005, 32'h0BAD_F00D, '0, 1'b1, 4);
    access(1'b0, 16'h0005, '0, 32'h0BAD_F00D, 1'b1, 0);
    check("mem_written", mem_model[16'h0005], 32'h0BAD_F00D);

    // Reset during MISS, stray ack one cycle later
    do_reset();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0003;
    @(negedge clk);
    @(negedge clk);
    check("abort_in_miss", 32'(mem_req_v[0]), 32'd1);
    @(posedge clk);
    #1;
    reset = 1'b1;
    cpu_req = 1'b0;
    @(negedge clk);
    late_ack = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("abort_mem_req", 32'(mem_req_v[0]), 32'd0);
    check("abort_ready", 32'(ready_v[0]), 32'd0);
    check("abort_no_fill", 32'(hit_v[0]), 32'd0);
    @(posedge clk);
    #1;
    access(1'b0, 16'h0003, '0, 32'hC0DE_0003, 1'b1, 5);

    // Direct-mapped instance: alternating conflicting addresses always miss
    do_reset();
    sel = 1'b1;
    access(1'b0, 16'h0007, '0, 32'hC0DE_0007, 1'b1, 5);
    access(1'b0, 16'h0017, '0, 32'hC0DE_0017, 1'b1, 5);
    access(1'b0, 16'h0007, '0, 32'hC0DE_0007, 1'b1, 5);
    access(1'b0, 16'h0017, '0, 32'hC0DE_0017, 1'b1, 5);
    access(1'b0, 16'h0017, '0, 32'hC0DE_0017, 1'b1, 0);

    repeat (3) @(posedge clk);
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
